decode_stage: RTL and testbench

Registered, parametrised instruction decode stage with a valid/ready handshake on both sides. It sits between instruction fetch (ROM read) and the register file / execute path. It slices each instruction into opcode, three register addresses and an immediate, then sign- or zero-extends the immediate. It flags opcodes not enabled in a legal mask, and buffers up to two decoded instructions so the output side can stall without dropping data.

---
 rtl/decode_stage.sv | 159 +++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode: slices opcode/rs1/rs2/rs3/imm, extends imm, flags illegal opcodes; 2-entry output buffer.
// Latency: 1 cycle from accepted push to out_valid; 1 instr/cycle with out_ready high.
// Backpressure: absorbs 2 entries, then in_ready drops (from registered count only). Optional stats: DECODE_STATS_EN.
module decode_stage #(
  parameter int                  INSTR_W    = 16,
  parameter int                  OP_W       = 4,
  parameter int                  REG_W      = 3,
  parameter int                  IMM_W      = 9,
  parameter int                  XLEN       = 16,
  parameter bit                  IMM_SIGNED = 1'b1,
  parameter logic [2**OP_W-1:0]  LEGAL_MASK = 16'h00FF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_opcode,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [REG_W-1:0]   out_rs3,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_illegal,
  output logic [31:0]        stat_decoded,
  output logic [31:0]        stat_illegal
);

  // Field layout must fit inside the instruction and the immediate must fit XLEN.
  if (OP_W + 3*REG_W > INSTR_W) begin : g_bad_fields
    $fatal(1, "decode_stage: OP_W + 3*REG_W exceeds INSTR_W");
  end
  if (IMM_W > INSTR_W - OP_W) begin : g_bad_imm
    $fatal(1, "decode_stage: IMM_W overlaps the opcode");
  end
  if (IMM_W > XLEN) begin : g_bad_xlen
    $fatal(1, "decode_stage: IMM_W exceeds XLEN");
  end

  // Entry layout, MSB first: opcode, rs1, rs2, rs3, imm, illegal.
  localparam int ENT_W = OP_W + 3*REG_W + XLEN + 1;

  logic [OP_W-1:0]  dec_opcode;
  logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rs3;
  logic [IMM_W-1:0] dec_imm_raw;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic [ENT_W-1:0] dec_ent;

  logic [ENT_W-1:0] mem_q [2];
  logic [ENT_W-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // Combinational slice and immediate extension of the incoming instruction.
  always_comb begin
    dec_opcode  = in_instr[INSTR_W-1 -: OP_W];
    dec_rs1     = in_instr[INSTR_W-OP_W-1 -: REG_W];
    dec_rs2     = in_instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
    dec_rs3     = in_instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
    dec_imm_raw = in_instr[IMM_W-1:0];
    dec_imm     = XLEN'(dec_imm_raw);
    // Shifting all-ones by IMM_W leaves exactly the upper bits to fill; empty when IMM_W == XLEN.
    if (IMM_SIGNED && dec_imm_raw[IMM_W-1]) begin
      dec_imm = dec_imm | ({XLEN{1'b1}} << IMM_W);
    end
    dec_illegal = ~LEGAL_MASK[dec_opcode];
    dec_ent     = {dec_opcode, dec_rs1, dec_rs2, dec_rs3, dec_imm, dec_illegal};
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  assign {out_opcode, out_rs1, out_rs2, out_rs3, out_imm, out_illegal} = head;

  // Buffer next-state: flush wins over push/pop and drops any same-cycle push.
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec_ent;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // Buffer state; reset clears entries too so outputs read zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded_q, stat_decoded_d;
  logic [31:0] stat_illegal_q, stat_illegal_d;

  // Saturating pop counters; a pop in a flush cycle still counts, flush never clears them.
  always_comb begin
    stat_decoded_d = stat_decoded_q;
    stat_illegal_d = stat_illegal_q;
    if (pop && stat_decoded_q != 32'hFFFF_FFFF) begin
      stat_decoded_d = stat_decoded_q + 32'd1;
    end
    if (pop && out_illegal && stat_illegal_q != 32'hFFFF_FFFF) begin
      stat_illegal_d = stat_illegal_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded_q <= 32'd0;
      stat_illegal_q <= 32'd0;
    end else begin
      stat_decoded_q <= stat_decoded_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_illegal = stat_illegal_q;
`else
  assign stat_decoded = 32'd0;
  assign stat_illegal = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: signed-imm and zero-extend instances share stimulus,
// checked against a queue model of the 2-entry buffer and arithmetic field decode.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rs1, out_rs2, out_rs3;
  logic [15:0] out_imm;
  logic [31:0] stat_decoded, stat_illegal;

  logic        in_ready_u, out_valid_u, out_illegal_u;
  logic [3:0]  out_opcode_u;
  logic [2:0]  out_rs1_u, out_rs2_u, out_rs3_u;
  logic [15:0] out_imm_u;
  logic [31:0] stat_decoded_u, stat_illegal_u;

  localparam logic [15:0] LEGAL = 16'h00FF;

  decode_stage #(.IMM_SIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
  );

  decode_stage #(.IMM_SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_instr(in_instr),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_opcode(out_opcode_u), .out_rs1(out_rs1_u), .out_rs2(out_rs2_u), .out_rs3(out_rs3_u),
    .out_imm(out_imm_u), .out_illegal(out_illegal_u),
    .stat_decoded(stat_decoded_u), .stat_illegal(stat_illegal_u)
  );

  always #5 clk = ~clk;

  // Reference model: queue of raw accepted instructions plus pop statistics.
  logic [15:0] q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_dec = 0;
  logic [31:0] m_ill = 0;

  function automatic logic [15:0] exp_imm(input int instr, input bit sgn);
    int v;
    v = instr % 512;
    if (sgn && v >= 256) v = v - 512 + 65536;
    return 16'(v);
  endfunction

  function automatic bit is_illegal(input int instr);
    return ((int'(LEGAL) >> (instr / 4096)) % 2) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef DECODE_STATS_EN
    chk("stat_decoded", stat_decoded, m_dec);
    chk("stat_illegal", stat_illegal, m_ill);
    chk("u_stats", {stat_decoded_u[15:0], stat_illegal_u[15:0]}, {m_dec[15:0], m_ill[15:0]});
`else
    chk("stat_decoded_off", stat_decoded, 32'd0);
    chk("stat_illegal_off", stat_illegal | stat_decoded_u | stat_illegal_u, 32'd0);
`endif
  endtask

  task automatic check_reset();
    chk("rst_out_valid", {out_valid, out_valid_u}, 32'd0);
    chk("rst_in_ready", {in_ready, in_ready_u}, 32'd3);
    chk("rst_fields", {out_opcode, out_rs1, out_rs2, out_rs3, out_illegal}, 32'd0);
    chk("rst_imm", {out_imm, out_imm_u}, 32'd0);
    chk("rst_fields_u", {out_opcode_u, out_rs1_u, out_rs2_u, out_rs3_u, out_illegal_u}, 32'd0);
    chk("rst_stats", stat_decoded | stat_illegal | stat_decoded_u | stat_illegal_u, 32'd0);
  endtask

  task automatic check_outs();
    int h;
    logic [3:0] e_op;
    logic [2:0] e_r1, e_r2, e_r3;
    logic       e_ill;
    chk("in_ready", {in_ready, in_ready_u}, (q.size() < 2) ? 32'd3 : 32'd0);
    chk("out_valid", {out_valid, out_valid_u}, (q.size() != 0) ? 32'd3 : 32'd0);
    if (q.size() != 0) begin
      h     = int'(q[0]);
      e_op  = 4'(h / 4096);
      e_r1  = 3'((h / 512) % 8);
      e_r2  = 3'((h / 64) % 8);
      e_r3  = 3'((h / 8) % 8);
      e_ill = is_illegal(h);
      chk("opcode", out_opcode, e_op);
      chk("rs1", out_rs1, e_r1);
      chk("rs2", out_rs2, e_r2);
      chk("rs3", out_rs3, e_r3);
      chk("imm_signed", out_imm, exp_imm(h, 1'b1));
      chk("illegal", out_illegal, e_ill);
      chk("imm_unsigned", out_imm_u, exp_imm(h, 1'b0));
      chk("u_fields", {out_opcode_u, out_rs1_u, out_rs2_u, out_rs3_u, out_illegal_u},
          {e_op, e_r1, e_r2, e_r3, e_ill});
    end
    check_stats();
  endtask

  // One clock cycle: drive, check at negedge, advance model, step past posedge.
  task automatic cycle(input bit v, input logic [15:0] ins, input bit ordy, input bit fl,
                       output bit acc);
    bit pop;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_outs();
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() != 0);
    if (pop) begin
      m_dec++;
      if (is_illegal(int'(q[0]))) m_ill++;
    end
    if (fl) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ins);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          acc;
    bit          v, ordy, fl;
    logic [15:0] pend;

    // Reset state.
    #12;
    check_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic decode, signed and zero-extended immediates, illegal opcode.
    cycle(1'b1, 16'h1A4C, 1'b1, 1'b0, acc);
    cycle(1'b1, 16'hF1FF, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Backpressure: two absorbed, third held off until space frees.
    cycle(1'b1, 16'h1000, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h2000, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h3000, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h3000, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h3000, 1'b1, 1'b0, acc);
    cycle(1'b1, 16'h3000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Flush with two entries buffered and in_valid high.
    cycle(1'b1, 16'h9123, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h2456, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h5555, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Flush with one entry: same-cycle pop counts, same-cycle push is dropped.
    cycle(1'b1, 16'hC777, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h6666, 1'b1, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Random traffic; producer holds an instruction until it is accepted.
    pend = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 32) == 0;
      cycle(v, pend, ordy, fl, acc);
      if (acc || fl) pend = 16'($urandom);
    end

    // Drain, then hold one entry and pulse reset between edges.
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b1, 16'hABCD, 1'b0, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    q.delete();
    m_dec = 0;
    m_ill = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 16'h1234, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
